// File: rtl/ann_argmax_stream.sv
// Streaming argmax over a frame of NUM_CLASSES scores with valid/ready on both sides.
// Define ARGMAX_MARGIN_EN to add runner-up tracking and the out_margin port.
module ann_argmax_stream #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int SIGNED      = 0,
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [SCORE_W-1:0] out_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W-1:0] out_margin
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Strict greater-than at SCORE_W, two's complement when SIGNED is set.
  function automatic logic greater(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic res;
    if (SIGNED != 0) begin
      res = ($signed(a) > $signed(b));
    end else begin
      res = (a > b);
    end
    return res;
  endfunction

  state_t               state_r;
  logic [IDX_W-1:0]     beat_cnt_r;
  logic [IDX_W-1:0]     best_idx_r;
  logic [SCORE_W-1:0]   best_r;
  logic [IDX_W-1:0]     out_index_r;
  logic [SCORE_W-1:0]   out_score_r;

  logic                 beat_s;
  logic                 first_s;
  logic                 last_s;
  logic                 new_best_s;
  logic [SCORE_W-1:0]   best_nxt_s;
  logic [IDX_W-1:0]     idx_nxt_s;

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == DONE);
  assign out_index = out_index_r;
  assign out_score = out_score_r;

  // Running-max update for the beat currently on the input.
  always_comb begin
    beat_s     = in_valid && in_ready;
    first_s    = (beat_cnt_r == '0);
    last_s     = (beat_cnt_r == LAST_IDX);
    new_best_s = first_s || greater(in_score, best_r);
    if (new_best_s) begin
      best_nxt_s = in_score;
      idx_nxt_s  = beat_cnt_r;
    end else begin
      best_nxt_s = best_r;
      idx_nxt_s  = best_idx_r;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic [SCORE_W-1:0] SCORE_MIN =
    (SIGNED != 0) ? {1'b1, {(SCORE_W-1){1'b0}}} : {SCORE_W{1'b0}};

  logic [SCORE_W-1:0] second_r;
  logic [SCORE_W-1:0] second_nxt_s;
  logic [SCORE_W-1:0] out_margin_r;

  assign out_margin = out_margin_r;

  // Runner-up follows the old best on a takeover, otherwise any score beating it.
  always_comb begin
    if (first_s) begin
      second_nxt_s = SCORE_MIN;
    end else if (greater(in_score, best_r)) begin
      second_nxt_s = best_r;
    end else if (greater(in_score, second_r)) begin
      second_nxt_s = in_score;
    end else begin
      second_nxt_s = second_r;
    end
  end

  // Runner-up and margin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_r     <= '0;
      out_margin_r <= '0;
    end else if (beat_s) begin
      second_r <= second_nxt_s;
      if (last_s) begin
        out_margin_r <= best_nxt_s - second_nxt_s;
      end
    end
  end
`endif

  // Frame FSM: accumulate beats, then hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      beat_cnt_r  <= '0;
      best_idx_r  <= '0;
      best_r      <= '0;
      out_index_r <= '0;
      out_score_r <= '0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (beat_s) begin
            best_r     <= best_nxt_s;
            best_idx_r <= idx_nxt_s;
            if (last_s) begin
              beat_cnt_r  <= '0;
              out_index_r <= idx_nxt_s;
              out_score_r <= best_nxt_s;
              state_r     <= DONE;
            end else begin
              beat_cnt_r <= beat_cnt_r + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= ACCUM;
          end
        end
        default: begin
          state_r    <= ACCUM;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ann_argmax_stream.sv
// Scoreboard bench for ann_argmax_stream: default, signed 8-bit and 4-class instances.
module tb_ann_argmax_stream;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] sc;
    logic [31:0] mg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  exp_t q_d[$];
  exp_t q_s[$];
  exp_t q_g[$];

  // default instance: 10 classes, 16-bit unsigned
  logic        d_valid, d_ready, d_out_valid, d_out_ready;
  logic [15:0] d_score, d_out_score;
  logic [3:0]  d_out_index;
  // signed instance: 10 classes, 8-bit signed
  logic        s_valid, s_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_score, s_out_score;
  logic [3:0]  s_out_index;
  // gap instance: 4 classes, 16-bit unsigned
  logic        g_valid, g_ready, g_out_valid, g_out_ready;
  logic [15:0] g_score, g_out_score;
  logic [1:0]  g_out_index;
`ifdef ARGMAX_MARGIN_EN
  logic [15:0] d_out_margin, g_out_margin;
  logic [7:0]  s_out_margin;
`endif

  ann_argmax_stream #(.NUM_CLASSES(10), .SCORE_W(16), .SIGNED(0)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready), .in_score(d_score),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_index(d_out_index),
    .out_score(d_out_score)
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(d_out_margin)
`endif
  );

  ann_argmax_stream #(.NUM_CLASSES(10), .SCORE_W(8), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready), .in_score(s_score),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_index(s_out_index),
    .out_score(s_out_score)
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(s_out_margin)
`endif
  );

  ann_argmax_stream #(.NUM_CLASSES(4), .SCORE_W(16), .SIGNED(0)) u_gap (
    .clk(clk), .rst_n(rst_n), .in_valid(g_valid), .in_ready(g_ready), .in_score(g_score),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .out_index(g_out_index),
    .out_score(g_out_score)
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(g_out_margin)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: in_ready never asserted within budget", nm);
  endtask

  // Each send starts #1 after an edge and returns #1 after the edge that took the beat.
  task automatic send_d(input logic [15:0] s);
    int t = 0;
    d_valid = 1'b1;
    d_score = s;
    while (!d_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!d_ready) timeout("def_send");
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] s);
    int t = 0;
    s_valid = 1'b1;
    s_score = s;
    while (!s_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!s_ready) timeout("sgn_send");
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_g(input logic [15:0] s);
    int t = 0;
    g_valid = 1'b1;
    g_score = s;
    while (!g_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!g_ready) timeout("gap_send");
    @(posedge clk); #1;
    g_valid = 1'b0;
  endtask

  task automatic frame_d(input logic [15:0] s [10], input int idx, input int sc, input int mg);
    q_d.push_back('{8'(idx), 32'(sc), 32'(mg)});
    for (int i = 0; i < 10; i++) send_d(s[i]);
  endtask

  task automatic frame_s(input logic [7:0] s [10], input int idx, input int sc, input int mg);
    q_s.push_back('{8'(idx), 32'(sc), 32'(mg)});
    for (int i = 0; i < 10; i++) send_s(s[i]);
  endtask

  // Monitor for the default instance: pop and compare on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d_out_valid && d_out_ready) begin
      if (q_d.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL def_extra_result: got index %0d, expected no result", d_out_index);
      end else begin
        e = q_d.pop_front();
        check("def_index", 32'(d_out_index), 32'(e.idx));
        check("def_score", 32'(d_out_score), e.sc);
`ifdef ARGMAX_MARGIN_EN
        check("def_margin", 32'(d_out_margin), e.mg);
`endif
      end
    end
  end

  // Monitor for the signed instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sgn_extra_result: got index %0d, expected no result", s_out_index);
      end else begin
        e = q_s.pop_front();
        check("sgn_index", 32'(s_out_index), 32'(e.idx));
        check("sgn_score", 32'(s_out_score), e.sc);
`ifdef ARGMAX_MARGIN_EN
        check("sgn_margin", 32'(s_out_margin), e.mg);
`endif
      end
    end
  end

  // Monitor for the gap instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && g_out_valid && g_out_ready) begin
      if (q_g.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL gap_extra_result: got index %0d, expected no result", g_out_index);
      end else begin
        e = q_g.pop_front();
        check("gap_index", 32'(g_out_index), 32'(e.idx));
        check("gap_score", 32'(g_out_score), e.sc);
`ifdef ARGMAX_MARGIN_EN
        check("gap_margin", 32'(g_out_margin), e.mg);
`endif
      end
    end
  end

  initial begin
    logic [15:0] gap_scores [4];
    int t;
    d_valid = 1'b0; d_score = '0; d_out_ready = 1'b1;
    s_valid = 1'b0; s_score = '0; s_out_ready = 1'b1;
    g_valid = 1'b0; g_score = '0; g_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(d_out_valid), 32'd0);
    check("reset_out_index", 32'(d_out_index), 32'd0);
    check("reset_out_score", 32'(d_out_score), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(d_ready), 32'd1);

    // tie keeps lower index; one-cycle valid pulse, next frame right after
    frame_d('{16'd5, 16'd9, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd8, 16'd7, 16'd4}, 1, 9, 0);
    check("pulse_valid_high", 32'(d_out_valid), 32'd1);
    check("pulse_in_ready_low", 32'(d_ready), 32'd0);
    @(posedge clk); #1;
    check("pulse_valid_low", 32'(d_out_valid), 32'd0);
    check("pulse_in_ready_back", 32'(d_ready), 32'd1);
    frame_d('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd100, 16'd0, 16'd50}, 7, 100, 50);
    @(posedge clk); #1;

    // backpressure: result held, stray beats ignored
    d_out_ready = 1'b0;
    frame_d('{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0, 16'd0, 16'd300}, 9, 300, 100);
    for (int i = 0; i < 5; i++) begin
      d_valid = 1'b1;
      d_score = 16'hFFFF;
      check("bp_out_valid", 32'(d_out_valid), 32'd1);
      check("bp_in_ready", 32'(d_ready), 32'd0);
      check("bp_out_index", 32'(d_out_index), 32'd9);
      check("bp_out_score", 32'(d_out_score), 32'd300);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    d_out_ready = 1'b1;
    frame_d('{16'd1000, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd999}, 0, 1000, 1);

    // extremes: all scores at full scale
    frame_d('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 65535, 0);
    @(posedge clk); #1;

    // reset mid-frame drops the partial frame
    for (int i = 0; i < 6; i++) send_d(16'd60000);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(d_out_valid), 32'd0);
    check("midrst_out_index", 32'(d_out_index), 32'd0);
    check("midrst_out_score", 32'(d_out_score), 32'd0);
`ifdef ARGMAX_MARGIN_EN
    check("midrst_out_margin", 32'(d_out_margin), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_d('{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100}, 9, 100, 10);

    // signed: -5,-2,-100,-3,... then a frame where unsigned order would differ
    frame_s('{8'hFB, 8'hFE, 8'h9C, 8'hFD, 8'hF9, 8'hF8, 8'hF7, 8'hF6, 8'hF5, 8'hF4}, 1, 8'hFE, 1);
    frame_s('{8'h05, 8'hFF, 8'h80, 8'h03, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'h7F, 122);

    // gaps between beats
    gap_scores = '{16'd1, 16'd2, 16'd40, 16'd3};
    q_g.push_back('{8'd2, 32'd40, 32'd37});
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send_g(gap_scores[i]);
    end

    t = 0;
    while ((q_d.size() + q_s.size() + q_g.size()) != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_def", 32'(q_d.size()), 32'd0);
    check("drain_sgn", 32'(q_s.size()), 32'd0);
    check("drain_gap", 32'(q_g.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
